// File: rtl/fsm_serial_pkg.sv
// -----------------------------------------------------------------------------
// fsm_serial_pkg
// Types and constants shared by the serial transmitter and the serial frame
// receiver.
//   state_t   : frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   LINE_IDLE : level of the serial line between frames
//   START_BIT : level of the start bit
//   STOP_BIT  : level of each stop bit
// -----------------------------------------------------------------------------
package fsm_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fsm_serial_tx.sv
// -----------------------------------------------------------------------------
// fsm_serial_tx
// Serial byte transmitter. Accepts a byte over a valid/ready handshake and
// sends it one bit per clock: start bit (0), DATA_BITS data bits LSB first,
// optional odd-parity bit, STOP_BITS stop bits (1). The line idles high.
//
// Optional feature macro: SERIAL_TX_PARITY_EN
//   defined   : a PARITY state carrying odd parity sits between DATA and STOP
//   undefined : frame goes straight from DATA to STOP
//
// Parameters
//   DATA_BITS : data bits per frame (5..8)
//   STOP_BITS : stop bits per frame (1 or 2)
// Ports
//   clk      : clock, rising edge
//   reset    : asynchronous, active-high reset
//   in_byte  : byte to transmit, sampled only on accept
//   in_valid : upstream has a byte on in_byte
//   in_ready : block can accept a byte this cycle (combinational)
//   out      : registered serial line
//   busy     : a frame is on the line
//   done     : high during the final stop-bit cycle of each frame
// -----------------------------------------------------------------------------
module fsm_serial_tx
    import fsm_serial_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    state_t               state;
    state_t               next_state;
    logic [DATA_BITS-1:0] shift;
    logic [CNT_W-1:0]     cnt;
    logic                 out_d;
    logic                 accept;
`ifdef SERIAL_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:  next_state = accept ? START : IDLE;
            START: next_state = DATA;
            DATA: begin
                if (cnt == DATA_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end else begin
                    next_state = DATA;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: next_state = STOP;
`endif
            STOP: begin
                if (cnt == STOP_LAST) begin
                    next_state = accept ? START : IDLE;
                end else begin
                    next_state = STOP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode. The line level is chosen from the state being entered so
    // that the registered out lines up with that state's cycle.
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == STOP) && (cnt == STOP_LAST);
        in_ready = (state == IDLE) || done;
        out_d    = LINE_IDLE;
        case (next_state)
            START:  out_d = START_BIT;
            DATA:   out_d = shift[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: out_d = parity_bit;
`endif
            STOP:   out_d = STOP_BIT;
            default: out_d = LINE_IDLE;
        endcase
    end

    // Shift register, bit counter and line register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out   <= LINE_IDLE;
            shift <= '0;
            cnt   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            out <= out_d;

            // A bit leaves on every edge that enters or stays in DATA.
            if (accept) begin
                shift <= in_byte;
`ifdef SERIAL_TX_PARITY_EN
                parity_bit <= ~(^in_byte);
`endif
            end else if (next_state == DATA) begin
                shift <= shift >> 1;
            end

            if ((next_state == DATA && state != DATA) ||
                (next_state == STOP && state != STOP)) begin
                cnt <= '0;
            end else if (state == DATA || state == STOP) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fsm_serial_tx.sv
module tb_fsm_serial_tx;

    parameter int STOP_BITS = 1;
    localparam int DATA_BITS = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FL = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic b;
        logic d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_seen = 0;

    fsm_serial_tx #(
        .DATA_BITS(DATA_BITS),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_byte (in_byte),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out     (out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line contents for one frame, one entry per cycle.
    task automatic push_frame(input logic [7:0] b);
        exp_t e;
        e.b = 1'b0; e.d = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < DATA_BITS; i++) begin
            e.b = b[i]; e.d = 1'b0;
            exp_q.push_back(e);
        end
`ifdef SERIAL_TX_PARITY_EN
        e.b = ~(^b); e.d = 1'b0;
        exp_q.push_back(e);
`endif
        for (int s = 0; s < STOP_BITS; s++) begin
            e.b = 1'b1; e.d = (s == STOP_BITS - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock: drive inputs after the falling edge, check ready before the
    // rising edge, check the line just after it.
    task automatic cycle(input logic v, input logic [7:0] b);
        exp_t e;
        logic acc;
        in_valid = v;
        in_byte  = b;
        #1;
        check("in_ready", in_ready, exp_q.size() == 0);
        acc = v && (exp_q.size() == 0);
        @(posedge clk);
        if (acc) push_frame(b);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out", out, e.b);
            check("done", done, e.d);
            check("busy", busy, 1);
        end else begin
            check("out_idle", out, 1);
            check("done_idle", done, 0);
            check("busy_idle", busy, 0);
        end
        if (done) done_seen++;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out", out, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);
        @(negedge clk);
        repeat (2) cycle(1'b0, 8'h00);

        // Single byte from idle
        done_seen = 0;
        cycle(1'b1, 8'hA5);
        repeat (FL + 1) cycle(1'b0, 8'h00);
        check("a5_done_count", done_seen, 1);

        // Back-to-back frames with valid held high
        done_seen = 0;
        cycle(1'b1, 8'h3C);
        repeat (FL) cycle(1'b1, 8'hFF);
        repeat (FL) cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        check("b2b_done_count", done_seen, 2);

        // in_byte toggling during a frame
        done_seen = 0;
        cycle(1'b1, 8'h5A);
        for (int i = 0; i < FL - 1; i++) cycle(1'b1, 8'($urandom));
        repeat (3) cycle(1'b0, 8'h00);
        check("tog_done_count", done_seen, 1);

        // Reset during the 4th data bit
        done_seen = 0;
        cycle(1'b1, 8'h81);
        repeat (4) cycle(1'b0, 8'h00);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_out", out, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_done_count", done_seen, 0);
        @(negedge clk);
        cycle(1'b1, 8'h55);
        repeat (FL + 1) cycle(1'b0, 8'h00);

        // Parity-sensitive and all-zero bytes
        cycle(1'b1, 8'h07);
        repeat (FL + 1) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h03);
        repeat (FL + 1) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h00);
        repeat (FL + 1) cycle(1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fsm_serial_tx.md
Name: fsm_serial_tx

Overview:
Serial byte transmitter that sits directly upstream of the team's serial frame receiver. It accepts bytes over a valid/ready handshake and drives the single-bit serial line, one bit per clock. Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1). The line idles high.

Parameters:
DATA_BITS, 8, data bits per frame (legal range 5..8)
STOP_BITS, 1, stop bits per frame (legal values 1 or 2)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
in_byte  input  DATA_BITS  byte to transmit; sampled only on accept
in_valid  input  1  upstream has a byte on in_byte
in_ready  output  1  block can accept a byte this cycle
out  output  1  registered serial line; feeds the receiver's serial input
busy  output  1  a frame is on the line (any state other than IDLE)
done  output  1  high exactly during the final stop-bit cycle of each frame

Behaviour:
- Reset (async, active-high): state=IDLE, out=1, busy=0, done=0, shift register=0, bit counter=0. in_ready=1 once reset deasserts.
- Reset mid-frame: on the next cycle out=1 and the frame is aborted. No done pulse. The byte is lost.
- States:
  - IDLE: out=1.
  - START: out=0, for 1 cycle.
  - DATA: DATA_BITS cycles; out=shift[0], then the register shifts right.
  - PARITY: 1 cycle, present only with the macro.
  - STOP: STOP_BITS cycles, out=1.
- in_ready is combinational: high in IDLE, and in the last STOP cycle. Low everywhere else.
- Accept occurs on a rising edge when in_valid && in_ready. in_byte loads the shift register.
- Latency: an accept at edge k puts the start bit on out in the cycle following edge k.
- Transitions:
  - IDLE→START on accept; otherwise stay in IDLE.
  - START→DATA.
  - DATA→DATA while the bit counter < DATA_BITS-1; then →PARITY (macro) or →STOP.
  - PARITY→STOP.
  - STOP: stay until STOP_BITS cycles have elapsed. In the last STOP cycle: accept→START (back-to-back, no idle gap); no accept→IDLE.
- Frame length = 1 + DATA_BITS + P + STOP_BITS cycles, where P=1 with the macro, else 0. Maximum throughput is one byte per frame length.
- Bit counter: width $clog2(DATA_BITS); it clears on entry to DATA and to STOP.
- in_valid held while not ready: no accept, and in_byte is not sampled. in_byte changes during a frame have no effect.
- done and busy are decoded from registered state, so they are glitch-free.
- Illegal or unreachable state: go to IDLE with out=1.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives odd parity, so the count of ones in data+parity is odd. The parity value is computed from in_byte at accept and registered.
- Undefined: no PARITY state; frame goes DATA→STOP. Frame length is reduced by 1.

Decomposition:
- Shared package fsm_serial_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), shared with the receiver side;
  - the constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- No sub-module is needed. Parity is an inline XOR reduction, and the shift/count logic lives in the single FSM module.

Test Plan:
- Byte 0xA5 accepted from IDLE, no macro, defaults → out over 10 cycles = 0,1,0,1,0,0,1,0,1,1. done high only in the 10th cycle. in_ready low in cycles 1-9.
- Two bytes back-to-back, 0x3C then 0xFF, with in_valid held high → second start bit immediately after the first frame's stop bit. Total 20 cycles, no idle cycle, 2 done pulses.
- in_valid=1 with in_byte toggling every cycle during a frame → only the byte present at the accept edge is transmitted. No extra accept occurs.
- reset asserted in the 4th data bit of 0x81 → out=1 the next cycle, done never pulses, in_ready=1 after release. A following byte 0x55 transmits correctly.
- SERIAL_TX_PARITY_EN defined → for 0x07 the parity bit is 0; for 0x03 the parity bit is 1. Frame length is 11; done is in cycle 11.
- STOP_BITS=2, byte 0x00 → out = 0,0,0,0,0,0,0,0,0,1,1. in_ready high only in cycle 11.
